// File: rtl/gf2_poly_div_seq_if.sv
// Request/result bundle for the bit-serial GF(2) polynomial divider.
// The requester drives the master side; the divider sits on the slave side.
interface gf2_poly_div_seq_if #(
    parameter int N  = 32,
    parameter int DW = 2*N-1
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [N-1:0]  divisor;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] quotient;
    logic [N-2:0]  remainder;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  err,
        input  quotient,
        input  remainder
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output err,
        output quotient,
        output remainder
    );
endinterface

// File: rtl/gf2_poly_div_seq.sv
// Bit-serial GF(2) long divider: one quotient bit per RUN cycle, highest first.
// Results are registered on entry to DONE and held until the next DONE or reset.
module gf2_poly_div_seq #(
    parameter int N  = 32,
    parameter int DW = 2*N-1
) (
    input  logic               clk,
    input  logic               rst,
    gf2_poly_div_seq_if.slave  bus
);
    localparam int DGW = $clog2(N);
    localparam int JW  = $clog2(DW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [DW-1:0]  r_w;
    logic [DW-1:0]  w_w_nxt;
    logic [DW-1:0]  r_q;
    logic [DW-1:0]  w_q_nxt;
    logic [N-1:0]   r_b;
    logic [N-1:0]   w_b_nxt;
    logic [DGW-1:0] r_deg;
    logic [DGW-1:0] w_deg_nxt;
    logic [JW-1:0]  r_j;
    logic [JW-1:0]  w_j_nxt;

    logic [DW-1:0]  r_quot;
    logic [DW-1:0]  w_quot_nxt;
    logic [N-2:0]   r_rem;
    logic [N-2:0]   w_rem_nxt;
    logic           r_err;
    logic           w_err_nxt;

    logic [DGW-1:0] w_msb;
    logic           w_div_zero;
    logic [JW-1:0]  w_top;
    logic [DW-1:0]  w_b_sh;

    // Degree of the divisor: index of its highest set coefficient
    always_comb begin
        w_msb = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.divisor[i]) begin
                w_msb = DGW'(i);
            end
        end
    end

    assign w_div_zero = (bus.divisor == '0);
    assign w_top      = r_j + JW'(r_deg);
    assign w_b_sh     = DW'(r_b) << r_j;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_w_nxt     = r_w;
        w_q_nxt     = r_q;
        w_b_nxt     = r_b;
        w_deg_nxt   = r_deg;
        w_j_nxt     = r_j;
        w_quot_nxt  = r_quot;
        w_rem_nxt   = r_rem;
        w_err_nxt   = r_err;

        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_div_zero) begin
                        w_state_nxt = S_DONE;
                        w_err_nxt   = 1'b1;
                        w_quot_nxt  = '0;
                        w_rem_nxt   = '0;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_w_nxt     = bus.dividend;
                        w_b_nxt     = bus.divisor;
                        w_deg_nxt   = w_msb;
                        w_j_nxt     = JW'(DW-1) - JW'(w_msb);
                        w_q_nxt     = '0;
                    end
                end
            end
            S_RUN: begin
                // Cancel the leading term when it is present at x^(j+deg)
                if (r_w[w_top]) begin
                    w_w_nxt      = r_w ^ w_b_sh;
                    w_q_nxt[r_j] = 1'b1;
                end
                if (r_j == '0) begin
                    w_state_nxt = S_DONE;
                    w_quot_nxt  = w_q_nxt;
                    w_rem_nxt   = w_w_nxt[N-2:0];
                    w_err_nxt   = 1'b0;
                end else begin
                    w_j_nxt = r_j - 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w    <= '0;
            r_q    <= '0;
            r_b    <= '0;
            r_deg  <= '0;
            r_j    <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_w    <= w_w_nxt;
            r_q    <= w_q_nxt;
            r_b    <= w_b_nxt;
            r_deg  <= w_deg_nxt;
            r_j    <= w_j_nxt;
            r_quot <= w_quot_nxt;
            r_rem  <= w_rem_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign bus.busy      = (r_state == S_RUN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.err       = r_err;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;
endmodule

// File: doc/gf2_poly_div_seq.md
Name: gf2_poly_div_seq

Overview:
- Sequential bit-serial GF(2) polynomial long divider; the inverse operation of the OKA_32bit carry-less multiplier.
- Takes a 63-bit dividend (the width of the 32x32 carry-less product) and a 32-bit divisor. Returns quotient and remainder with all arithmetic XOR-based (no carries).
- Used to reduce or verify OKA products, and as the basis for GF(2^m) modular reduction downstream of the multiplier.

Parameters:
- N, 32, divisor width in bits.
- DW, 2*N-1 (63), dividend and quotient width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; accepted only in IDLE.
- dividend  input  DW  dividend polynomial, bit i = coefficient of x^i.
- divisor  input  N  divisor polynomial, bit i = coefficient of x^i.
- busy  output  1  high while an operation is in flight (RUN).
- done  output  1  one-cycle pulse; results valid.
- err  output  1  valid with done; 1 = divisor was zero.
- quotient  output  DW  quotient polynomial.
- remainder  output  N-1  remainder polynomial; degree < deg(divisor).

Behaviour:
- Clock and reset: single clock domain (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, busy=0, done=0, err=0, quotient=0, remainder=0, all internal registers 0.
- Reset mid-operation aborts the operation in the same edge. No done is issued and outputs clear to 0.
- States are IDLE, RUN, DONE.
- IDLE, start=1, divisor!=0:
  - Latch W<=dividend, B<=divisor.
  - deg <= index of the most-significant set bit of divisor (0..N-1).
  - j <= DW-1-deg; internal Q<=0; go to RUN.
- IDLE, start=1, divisor==0: go directly to DONE with err=1, quotient=0, remainder=0.
- RUN, each cycle:
  - If W[j+deg]==1, then W <= W ^ (B << j) and Q[j] <= 1.
  - If j==0, go to DONE; else j <= j-1.
  - Exactly K = DW-deg RUN cycles.
- DONE, one cycle:
  - done=1; quotient=Q; remainder=W[N-2:0]; err as determined; busy=0.
  - Next state IDLE.
- Latency: start sampled at edge t, then RUN during cycles t+1..t+K, then done high in cycle t+K+1.
  - deg=31 gives K=32; deg=0 gives K=63.
  - Zero divisor: done in cycle t+1.
- busy is 1 exactly in RUN cycles.
- start while RUN or DONE is ignored, with no queuing. Inputs are sampled only at the accepting edge, so they may change afterwards.
- quotient, remainder and err are registered. They update only when entering DONE and hold until the next DONE or reset.
- Width rules:
  - Quotient degree <= DW-1-deg, so it fits in DW bits.
  - W bits at index >= deg are 0 after RUN, so remainder = W[N-2:0] holds the full remainder.
  - With deg=0, remainder=0.
- Invariant at done with err=0: clmul(quotient, divisor) XOR remainder == dividend.

Test Plan:
- Reset, then dividend=63'h7 (x^2+x+1), divisor=32'h3, start -> done at t+63, quotient=63'h2, remainder=31'h1, err=0; busy high for 62 cycles.
- dividend=63'h7FFF_FFFF_FFFF_FFFF, divisor=32'h8000_0000, start -> done at t+33, quotient=63'hFFFF_FFFF, remainder=31'h7FFF_FFFF.
- dividend=63'h1234_5678_9ABC_DEF0, divisor=32'h1 -> done at t+64, quotient=dividend, remainder=0.
- Round trip:
  - a=32'd4128831000, b=32'd3997757000; P = OKA_32bit(a,b).
  - Apply dividend=P, divisor=b -> quotient=a, remainder=0.
  - Then dividend=P^63'h5, divisor=b -> quotient=a, remainder=31'h5.
- divisor=0, start -> done at t+1, err=1, quotient=0, remainder=0, busy never asserted.
- Control edge cases:
  - Pulse start again during RUN with different operands -> ignored; the first result is unchanged.
  - Assert rst mid-RUN -> next cycle busy=0, no done, outputs 0.
  - A new start afterwards -> normal completion.
  - Randomized 10k operands checked against the invariant above.
